cfo_phase_gen: RTL and testbench
================================

# cfo_phase_gen

Coarse carrier-frequency-offset phase generator in the sync-short path. Consumes the angle estimates produced by the iterative arctan CORDIC from the lag-16 autocorrelation. It averages a programmable number of estimates, converts the result to a per-sample phase increment, and emits a wrapped, running de-rotation phase for every received sample to the downstream rotation CORDIC.

## Interface
- AVG_LOG2, 2: log2 of the number of arctan estimates averaged before lock (0..4).
- LAG_LOG2, 4: log2 of the autocorrelation lag in samples (short preamble = 16).
- CLK  in  1  clock.
- s_RST  in  1  reset, synchronous, active-high; clock CLK.
- Phase_in  in  32  signed arctan angle, radians × 2^28 (pi = 843314856).
- Phase_valid  in  1  one-cycle strobe qualifying Phase_in.
- Lock_req  in  1  one-cycle pulse: start a new estimate (preamble detected).
- Sample_strobe  in  1  one pulse per received sample to be de-rotated.
- Rot_phase  out  32  signed de-rotation phase for the current sample, same scaling, in [-pi, pi).
- Rot_strobe  out  1  qualifies Rot_phase.
- Freq_inc  out  32  signed per-sample phase increment in use.
- Est_locked  out  1  high while in LOCKED.

## Operation
- Constants: PI_VAL = 843314856, TWO_PI_VAL = 1686629712.
- FSM states:
  - IDLE:
    - Lock_req → COLLECT; clears Sum (36-bit signed) and Cnt.
  - COLLECT:
    - On each Phase_valid: Sum += sign-extended Phase_in; Cnt++.
    - When Cnt reaches 2^AVG_LOG2 (counting the current valid) → CALC.
    - Lock_req in COLLECT restarts the collection: Sum = 0, Cnt = 0.
  - CALC, one cycle:
    - Freq_inc ← −(Sum >>> (AVG_LOG2 + LAG_LOG2)), truncated to 32 bits.
    - Acc ← 0.
    - → LOCKED.
  - LOCKED:
    - On each Sample_strobe: Rot_phase ← Acc; Acc ← wrap(Acc + Freq_inc).
    - Lock_req → COLLECT with Sum and Cnt cleared. Freq_inc is held until the next CALC.
- Wrap:
  - s = Acc + Freq_inc, computed in 33 bits.
  - If s ≥ PI_VAL, subtract TWO_PI_VAL.
  - If s < −PI_VAL, add TWO_PI_VAL.
  - Result is always in [-pi, pi). A single correction suffices because |Freq_inc| ≤ pi/16.
- No unwrapping is applied to the estimates. Averaging estimates that straddle ±pi is out of scope.
- Sample_strobe in IDLE, COLLECT or CALC: Rot_strobe still fires with Rot_phase = 0 (pass-through, no correction). This keeps the sample stream continuous.
- Phase_valid outside COLLECT is ignored.
- Simultaneous Lock_req and Phase_valid in COLLECT: the restart wins and the estimate is discarded.
- Simultaneous Lock_req and Sample_strobe in LOCKED: that sample is still output with the current Acc, then the FSM moves to COLLECT.

## Timing
- Reset values:
  - Rot_phase = 0, Rot_strobe = 0, Freq_inc = 0, Est_locked = 0.
  - State IDLE; Sum, Cnt and Acc = 0.
- Reset mid-operation returns everything to the reset values on the next edge. Any partial average is lost.
- Rot_strobe and Rot_phase are registered: they assert exactly 1 cycle after Sample_strobe and stay high for 1 cycle.
- Back-to-back Sample_strobe is supported at 1 per cycle.
- Est_locked rises the cycle after CALC; it is registered from the state.
- From the last required Phase_valid to Est_locked high takes 2 cycles: COLLECT→CALC, then CALC→LOCKED.
- A Sample_strobe arriving during CALC yields phase 0. The first corrected output is for the first strobe seen in LOCKED, and its phase is 0.

## Structure
- Shared package `sync_pkg`: PI_VAL, TWO_PI_VAL, the phase width (32), and the state encoding. The upstream arctan and the downstream rotator use the same constants.
- Sub-module `phase_wrap_add`: combinational 33-bit add with ±2pi correction. It is reused by the rotator's accumulator.
- Top-level contents: FSM, averaging accumulator, increment register, Acc, and output registers.

## Test plan
- Reset → all outputs 0, Est_locked = 0. Sample_strobe in IDLE → Rot_strobe one cycle later with Rot_phase = 0.
- AVG_LOG2 = 2. Lock_req, then four Phase_valid with 160000 → Freq_inc = −10000, Est_locked high 2 cycles after the 4th valid. Five consecutive Sample_strobe → Rot_phase 0, −10000, −20000, −30000, −40000.
- Wrap: four estimates of 800000000 → Freq_inc = −50000000. Strobes k = 0..16 give −50000000·k. Strobe 17 gives 836629712 (−850000000 + 2pi).
- Negative-input wrap: four estimates of −800000000 → Freq_inc = +50000000. Strobe 17 gives −836629712.
- Lock_req after two valids in COLLECT, then four valids of 320000 → average uses only the last four, Freq_inc = −20000.
- s_RST asserted in LOCKED mid-stream → next cycle: Est_locked = 0, Freq_inc = 0. Following strobes give phase 0.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared sync-short constants and types.
//   PHASE_W    : width of all phase words (radians x 2^28, signed)
//   PI_VAL     : pi in phase units, 33-bit signed for overflow-free compares
//   TWO_PI_VAL : 2*pi in phase units, 33-bit signed
//   cfo_state_e: CFO phase generator FSM encoding
package sync_pkg;
   localparam int PHASE_W = 32;
   localparam logic signed [PHASE_W:0] PI_VAL     = 33'sd843314856;
   localparam logic signed [PHASE_W:0] TWO_PI_VAL = 33'sd1686629712;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CALC    = 2'd2,
      ST_LOCKED  = 2'd3
   } cfo_state_e;
endpackage

// File: rtl/phase_wrap_add.sv
// Combinational phase add with a single +/-2pi correction.
//   a_in, b_in : signed phases; a_in in [-pi, pi), |b_in| <= pi/16
//   sum_out    : a_in + b_in wrapped into [-pi, pi)
module phase_wrap_add
   import sync_pkg::*;
(
   input  logic signed [PHASE_W-1:0] a_in,
   input  logic signed [PHASE_W-1:0] b_in,
   output logic signed [PHASE_W-1:0] sum_out
);
   // One guard bit so the raw sum cannot overflow before correction.
   logic signed [PHASE_W:0] s;

   always_comb begin
      s = {a_in[PHASE_W-1], a_in} + {b_in[PHASE_W-1], b_in};
      if (s >= PI_VAL)
         sum_out = PHASE_W'(s - TWO_PI_VAL);
      else if (s < -PI_VAL)
         sum_out = PHASE_W'(s + TWO_PI_VAL);
      else
         sum_out = PHASE_W'(s);
   end
endmodule

// File: rtl/cfo_phase_gen.sv
// Coarse CFO phase generator: averages 2^AVG_LOG2 arctan estimates, turns
// the mean into a per-sample increment and emits a wrapped running
// de-rotation phase for every sample strobe.
//   CLK, s_RST    : clock, synchronous active-high reset
//   Phase_in      : signed arctan estimate, qualified by Phase_valid
//   Lock_req      : (re)start an estimate
//   Sample_strobe : one pulse per sample to de-rotate
//   Rot_phase     : registered de-rotation phase, qualified by Rot_strobe
//   Freq_inc      : per-sample increment in use
//   Est_locked    : high while locked
module cfo_phase_gen
   import sync_pkg::*;
#(
   parameter int AVG_LOG2 = 2,
   parameter int LAG_LOG2 = 4
) (
   input  logic                      CLK,
   input  logic                      s_RST,
   input  logic signed [PHASE_W-1:0] Phase_in,
   input  logic                      Phase_valid,
   input  logic                      Lock_req,
   input  logic                      Sample_strobe,
   output logic signed [PHASE_W-1:0] Rot_phase,
   output logic                      Rot_strobe,
   output logic signed [PHASE_W-1:0] Freq_inc,
   output logic                      Est_locked
);
   localparam int         SHIFT   = AVG_LOG2 + LAG_LOG2;
   localparam logic [4:0] CNT_TGT = 5'(1 << AVG_LOG2);

   cfo_state_e                state_q, state_d;
   logic signed [35:0]        sum_q, sum_d;
   logic        [4:0]         cnt_q, cnt_d;
   logic signed [PHASE_W-1:0] freq_q, freq_d;
   logic signed [PHASE_W-1:0] acc_q, acc_d;
   logic signed [PHASE_W-1:0] rot_phase_q, rot_phase_d;
   logic                      rot_strobe_q, rot_strobe_d;
   logic                      locked_q, locked_d;
   logic signed [PHASE_W-1:0] acc_next;

   phase_wrap_add u_wrap (
      .a_in    (acc_q),
      .b_in    (freq_q),
      .sum_out (acc_next)
   );

   always_comb begin
      state_d      = state_q;
      sum_d        = sum_q;
      cnt_d        = cnt_q;
      freq_d       = freq_q;
      acc_d        = acc_q;
      // Every sample is forwarded; only LOCKED applies a correction.
      rot_strobe_d = Sample_strobe;
      rot_phase_d  = '0;

      case (state_q)
         ST_IDLE: begin
            if (Lock_req) begin
               state_d = ST_COLLECT;
               sum_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_COLLECT: begin
            // Restart beats a coincident estimate.
            if (Lock_req) begin
               sum_d = '0;
               cnt_d = '0;
            end else if (Phase_valid) begin
               sum_d = sum_q + {{4{Phase_in[PHASE_W-1]}}, Phase_in};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q + 5'd1 == CNT_TGT)
                  state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            freq_d  = PHASE_W'(-(sum_q >>> SHIFT));
            acc_d   = '0;
            state_d = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (Sample_strobe) begin
               rot_phase_d = acc_q;
               acc_d       = acc_next;
            end
            if (Lock_req) begin
               state_d = ST_COLLECT;
               sum_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge CLK) begin
      if (s_RST) begin
         state_q      <= ST_IDLE;
         sum_q        <= '0;
         cnt_q        <= '0;
         freq_q       <= '0;
         acc_q        <= '0;
         rot_phase_q  <= '0;
         rot_strobe_q <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         cnt_q        <= cnt_d;
         freq_q       <= freq_d;
         acc_q        <= acc_d;
         rot_phase_q  <= rot_phase_d;
         rot_strobe_q <= rot_strobe_d;
         locked_q     <= locked_d;
      end
   end

   assign Rot_phase  = rot_phase_q;
   assign Rot_strobe = rot_strobe_q;
   assign Freq_inc   = freq_q;
   assign Est_locked = locked_q;
endmodule

// File: tb/tb_cfo_phase_gen.sv
// Bench for cfo_phase_gen: directed scenarios plus random traffic, all
// checked against a transaction-level model (mean of the estimate list,
// phase of sample k = k*inc reduced modulo 2pi).
module tb_cfo_phase_gen;
   localparam longint PI  = 843314856;
   localparam longint TPI = 1686629712;
   localparam int     N   = 4;   // 2^AVG_LOG2
   localparam int     SH  = 6;   // AVG_LOG2 + LAG_LOG2

   logic               CLK = 1'b0;
   logic               s_RST = 1'b0;
   logic signed [31:0] Phase_in = '0;
   logic               Phase_valid = 1'b0;
   logic               Lock_req = 1'b0;
   logic               Sample_strobe = 1'b0;
   logic signed [31:0] Rot_phase;
   logic               Rot_strobe;
   logic signed [31:0] Freq_inc;
   logic               Est_locked;

   int n_chk = 0;
   int n_fail = 0;

   cfo_phase_gen #(.AVG_LOG2(2), .LAG_LOG2(4)) dut (
      .CLK           (CLK),
      .s_RST         (s_RST),
      .Phase_in      (Phase_in),
      .Phase_valid   (Phase_valid),
      .Lock_req      (Lock_req),
      .Sample_strobe (Sample_strobe),
      .Rot_phase     (Rot_phase),
      .Rot_strobe    (Rot_strobe),
      .Freq_inc      (Freq_inc),
      .Est_locked    (Est_locked)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Model: 0 idle, 1 collecting, 2 computing, 3 locked.
   int          m_mode = 0;
   longint      m_est[$];
   longint      m_inc = 0;
   longint      m_k = 0;
   longint      e_phase = 0, e_inc = 0;
   bit          e_strobe = 0, e_locked = 0;
   bit          chk_en = 0;

   function automatic longint wrap_pi(input longint x);
      longint r;
      r = (x + PI) % TPI;
      if (r < 0) r += TPI;
      return r - PI;
   endfunction

   function automatic longint mean_inc();
      longint s = 0;
      longint t;
      foreach (m_est[i]) s += m_est[i];
      t = -(s >>> SH);
      return longint'($signed(t[31:0]));
   endfunction

   task automatic model(input bit rst, lock, valid, input longint ph, input bit strobe);
      if (rst) begin
         m_mode = 0; m_est.delete(); m_inc = 0; m_k = 0;
         e_phase = 0; e_strobe = 0; e_inc = 0; e_locked = 0;
         return;
      end
      e_strobe = strobe;
      e_phase  = (m_mode == 3 && strobe) ? wrap_pi(m_inc * m_k) : 0;
      case (m_mode)
         0: if (lock) begin m_mode = 1; m_est.delete(); end
         1: if (lock) m_est.delete();
            else if (valid) begin
               m_est.push_back(ph);
               if (m_est.size() == N) m_mode = 2;
            end
         2: begin m_inc = mean_inc(); m_k = 0; m_mode = 3; end
         default: begin
            if (strobe) m_k++;
            if (lock) begin m_mode = 1; m_est.delete(); end
         end
      endcase
      e_inc    = m_inc;
      e_locked = (m_mode == 3);
   endtask

   task automatic cyc(input bit rst, lock, valid, input longint ph, input bit strobe);
      @(negedge CLK);
      if (chk_en) begin
         chk("rot_strobe", longint'(Rot_strobe), longint'(e_strobe));
         chk("rot_phase",  longint'(Rot_phase),  e_phase);
         chk("freq_inc",   longint'(Freq_inc),   e_inc);
         chk("est_locked", longint'(Est_locked), longint'(e_locked));
      end
      s_RST = rst; Lock_req = lock; Phase_valid = valid;
      Phase_in = 32'(ph); Sample_strobe = strobe;
      model(rst, lock, valid, ph, strobe);
      chk_en = 1;
   endtask

   task automatic after_edge();
      @(posedge CLK); #1;
   endtask

   task automatic estimate(input longint v);
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < N; i++) cyc(0, 0, 1, v, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset and pass-through in IDLE
      cyc(1, 0, 0, 0, 0);
      after_edge();
      chk("rst_locked", longint'(Est_locked), 0);
      chk("rst_freq", longint'(Freq_inc), 0);
      chk("rst_strobe", longint'(Rot_strobe), 0);
      cyc(0, 0, 0, 0, 1);
      after_edge();
      chk("idle_strobe", longint'(Rot_strobe), 1);
      chk("idle_phase", longint'(Rot_phase), 0);

      // Basic average and lock latency
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < N; i++) cyc(0, 0, 1, 160000, 0);
      after_edge();
      chk("lock_early", longint'(Est_locked), 0);
      cyc(0, 0, 0, 0, 0);
      after_edge();
      chk("lock_rise", longint'(Est_locked), 1);
      chk("inc_basic", longint'(Freq_inc), -10000);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0, 0, 1);
         after_edge();
         chk("phase_basic", longint'(Rot_phase), -10000 * longint'(k));
      end

      // Positive-estimate wrap
      estimate(800000000);
      chk("inc_pos", longint'(Freq_inc), -50000000);
      for (int k = 0; k < 18; k++) begin
         cyc(0, 0, 0, 0, 1);
         after_edge();
         chk("wrap_pos", longint'(Rot_phase),
             (k == 17) ? 836629712 : -50000000 * longint'(k));
      end

      // Negative-estimate wrap
      estimate(-800000000);
      chk("inc_neg", longint'(Freq_inc), 50000000);
      for (int k = 0; k < 18; k++) begin
         cyc(0, 0, 0, 0, 1);
         after_edge();
         chk("wrap_neg", longint'(Rot_phase),
             (k == 17) ? -836629712 : 50000000 * longint'(k));
      end

      // Restart mid-collection discards the partial average
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 700000000, 0);
      cyc(0, 0, 1, 700000000, 0);
      estimate(320000);
      chk("inc_restart", longint'(Freq_inc), -20000);

      // Reset while locked and streaming
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      after_edge();
      chk("rst_mid_locked", longint'(Est_locked), 0);
      chk("rst_mid_freq", longint'(Freq_inc), 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 1);
         after_edge();
         chk("rst_mid_phase", longint'(Rot_phase), 0);
      end

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         bit     r, l, v, s;
         longint p;
         r = ($urandom_range(0, 999) == 0);
         l = ($urandom_range(0, 99) < 2);
         v = ($urandom_range(0, 2) == 0);
         s = $urandom_range(0, 1) == 1;
         p = longint'($urandom_range(0, 1686629711)) - PI;
         cyc(r, l, v, p, s);
      end
      cyc(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
